// File: rtl/muldiv_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_issue_ctrl_pkg
// Brief    : Shared widths, M-extension funct3 codes and issue FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_issue_ctrl_pkg;

  localparam int MD_XLEN           = 32;
  localparam int MD_N_HARTS        = 4;
  localparam int MD_HART_ID_W      = 2;
  localparam int MD_REG_ADDR_W     = 5;
  localparam int MD_TIMEOUT_CYCLES = 64;
  localparam int MD_OP_W           = 3;

  localparam logic [MD_OP_W-1:0] OP_MUL    = 3'b000;
  localparam logic [MD_OP_W-1:0] OP_MULH   = 3'b001;
  localparam logic [MD_OP_W-1:0] OP_MULHSU = 3'b010;
  localparam logic [MD_OP_W-1:0] OP_MULHU  = 3'b011;
  localparam logic [MD_OP_W-1:0] OP_DIV    = 3'b100;
  localparam logic [MD_OP_W-1:0] OP_DIVU   = 3'b101;
  localparam logic [MD_OP_W-1:0] OP_REM    = 3'b110;
  localparam logic [MD_OP_W-1:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } md_state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_issue_ctrl_if
// Brief    : MULDIV request/response bundle; master = issue side, slave = unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_issue_ctrl_if
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int XLEN       = MD_XLEN,
  parameter int HART_ID_W  = MD_HART_ID_W,
  parameter int REG_ADDR_W = MD_REG_ADDR_W
) ();

  logic                  muldiv_start;
  logic [MD_OP_W-1:0]    muldiv_op;
  logic [XLEN-1:0]       muldiv_a;
  logic [XLEN-1:0]       muldiv_b;
  logic [HART_ID_W-1:0]  muldiv_hart_id;
  logic [REG_ADDR_W-1:0] muldiv_rd;

  logic                  muldiv_busy;
  logic                  muldiv_done;
  logic [XLEN-1:0]       muldiv_result;
  logic [HART_ID_W-1:0]  muldiv_done_hart_id;
  logic [REG_ADDR_W-1:0] muldiv_done_rd;

  modport master (
    output muldiv_start, muldiv_op, muldiv_a, muldiv_b, muldiv_hart_id, muldiv_rd,
    input  muldiv_busy, muldiv_done, muldiv_result, muldiv_done_hart_id, muldiv_done_rd
  );

  modport slave (
    input  muldiv_start, muldiv_op, muldiv_a, muldiv_b, muldiv_hart_id, muldiv_rd,
    output muldiv_busy, muldiv_done, muldiv_result, muldiv_done_hart_id, muldiv_done_rd
  );

endinterface
`default_nettype wire

// File: rtl/muldiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_issue_ctrl
// Brief    : Single-op MUL/DIV issue controller with hart blocking and
//            arbitrated regfile writeback. MULDIV_ISSUE_TIMEOUT_EN adds a
//            WAIT-state watchdog that forces an all-ones writeback.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_issue_ctrl
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int XLEN       = MD_XLEN,
  parameter int N_HARTS    = MD_N_HARTS,
  parameter int HART_ID_W  = MD_HART_ID_W,
  parameter int REG_ADDR_W = MD_REG_ADDR_W
`ifdef MULDIV_ISSUE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = MD_TIMEOUT_CYCLES
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  ex_valid_i,
  input  logic [MD_OP_W-1:0]    ex_op_i,
  input  logic [XLEN-1:0]       ex_a_i,
  input  logic [XLEN-1:0]       ex_b_i,
  input  logic [HART_ID_W-1:0]  ex_hart_id_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  output logic                  ex_ready_o,

  muldiv_issue_ctrl_if.master   md,

  output logic [N_HARTS-1:0]    hart_blocked_o,

  output logic                  wb_valid_o,
  output logic [HART_ID_W-1:0]  wb_hart_id_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic [XLEN-1:0]       wb_data_o,
  input  logic                  wb_ready_i,

  output logic                  muldiv_err_o
);

  md_state_e             state_q, state_d;
  logic [MD_OP_W-1:0]    op_q;
  logic [XLEN-1:0]       a_q, b_q, data_q;
  logic [HART_ID_W-1:0]  hart_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [N_HARTS-1:0]    blocked_q;
  logic                  err_q, err_d;

  logic accept, load_op, capture, timeout_fill, wb_fire, done_match, wd_expired;

  assign done_match = md.muldiv_done
                   && (md.muldiv_done_hart_id == hart_q)
                   && (md.muldiv_done_rd == rd_q);

`ifdef MULDIV_ISSUE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else if (state_q == ST_ISSUE) begin
      wd_cnt_q <= '0;
    end else if (state_q == ST_WAIT) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle without a matching done.
  assign wd_expired = (state_q == ST_WAIT) && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    accept          = 1'b0;
    load_op         = 1'b0;
    capture         = 1'b0;
    timeout_fill    = 1'b0;
    wb_fire         = 1'b0;
    err_d           = 1'b0;
    md.muldiv_start = 1'b0;
    wb_valid_o      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        accept = ex_valid_i && !md.muldiv_busy;
        // Writes to x0 are retired here without occupying the unit.
        if (accept && (ex_rd_i != '0)) begin
          load_op = 1'b1;
          state_d = ST_ISSUE;
        end
        err_d = md.muldiv_done;
      end
      ST_ISSUE, ST_WAIT: begin
        if (state_q == ST_ISSUE) begin
          md.muldiv_start = 1'b1;
          state_d         = ST_WAIT;
        end
        if (done_match) begin
          capture = 1'b1;
          state_d = ST_WB;
        end else if (md.muldiv_done) begin
          err_d = 1'b1;
        end else if (wd_expired) begin
          err_d        = 1'b1;
          timeout_fill = 1'b1;
          state_d      = ST_WB;
        end
      end
      ST_WB: begin
        wb_valid_o = 1'b1;
        err_d      = md.muldiv_done;
        if (wb_ready_i) begin
          wb_fire = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hart_q    <= '0;
      rd_q      <= '0;
      data_q    <= '0;
      blocked_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= err_d;
      if (load_op) begin
        op_q      <= ex_op_i;
        a_q       <= ex_a_i;
        b_q       <= ex_b_i;
        hart_q    <= ex_hart_id_i;
        rd_q      <= ex_rd_i;
        blocked_q <= N_HARTS'(1) << ex_hart_id_i;
      end else if (wb_fire) begin
        blocked_q[hart_q] <= 1'b0;
      end
      if (capture) begin
        data_q <= md.muldiv_result;
      end else if (timeout_fill) begin
        data_q <= '1;
      end
    end
  end

  assign ex_ready_o        = accept;
  assign md.muldiv_op      = op_q;
  assign md.muldiv_a       = a_q;
  assign md.muldiv_b       = b_q;
  assign md.muldiv_hart_id = hart_q;
  assign md.muldiv_rd      = rd_q;
  assign hart_blocked_o    = blocked_q;
  assign wb_hart_id_o      = hart_q;
  assign wb_rd_o           = rd_q;
  assign wb_data_o         = data_q;
  assign muldiv_err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_issue_ctrl
// Brief    : Scoreboard bench with a fake MUL/DIV unit and RV32M result model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_issue_ctrl;
  import muldiv_issue_ctrl_pkg::*;

  localparam int XLEN = 32;
  localparam int NH   = 4;
  localparam int HW   = 2;
  localparam int RW   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            ex_valid = 1'b0;
  logic [2:0]      ex_op = '0;
  logic [XLEN-1:0] ex_a = '0, ex_b = '0;
  logic [HW-1:0]   ex_hart = '0;
  logic [RW-1:0]   ex_rd = '0;
  logic            ex_ready;
  logic [NH-1:0]   hart_blocked;
  logic            wb_valid;
  logic [HW-1:0]   wb_hart_id;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_ready;
  logic            muldiv_err;

  muldiv_issue_ctrl_if #(.XLEN(XLEN), .HART_ID_W(HW), .REG_ADDR_W(RW)) bus ();

  muldiv_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid), .ex_op_i(ex_op), .ex_a_i(ex_a), .ex_b_i(ex_b),
    .ex_hart_id_i(ex_hart), .ex_rd_i(ex_rd), .ex_ready_o(ex_ready),
    .md(bus),
    .hart_blocked_o(hart_blocked),
    .wb_valid_o(wb_valid), .wb_hart_id_o(wb_hart_id), .wb_rd_o(wb_rd),
    .wb_data_o(wb_data), .wb_ready_i(wb_ready),
    .muldiv_err_o(muldiv_err)
  );

  typedef struct {
    logic [HW-1:0]   hart;
    logic [RW-1:0]   rd;
    logic [2:0]      op;
    logic [XLEN-1:0] a, b, res;
  } exp_t;

  exp_t q[$];
  int   vectors = 0, miscompares = 0;
  int   err_seen = 0, err_exp_u = 0, err_exp_s = 0;
  int   u_lat = 0, u_bad = 0, wb_stall_cfg = 0;
  bit   u_nodone = 1'b0;
  int   spur_req = 0;
  bit   issued = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_sim();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  // RV32M semantics straight from the ISA rules
  function automatic logic [XLEN-1:0] ref_result(input logic [2:0] op, input logic [XLEN-1:0] a, b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint          ub = longint'({32'b0, b});
    longint unsigned ua = {32'b0, a};
    logic [63:0]     p;
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = ua * longint'(ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Fake MUL/DIV unit: answers L cycles after start, optionally with a bad done first.
  initial begin : fake_unit
    bit            armed = 1'b0;
    int            k = 0, lat = 0, bad = 0, spur_ack = 0;
    logic [2:0]    r_op;
    logic [31:0]   r_a, r_b;
    logic [HW-1:0] r_hart;
    logic [RW-1:0] r_rd;
    bus.muldiv_done = 1'b0;
    bus.muldiv_result = '0;
    bus.muldiv_done_hart_id = '0;
    bus.muldiv_done_rd = '0;
    forever begin
      @(negedge clk);
      bus.muldiv_done = 1'b0;
      if (!rst_n) begin
        armed = 1'b0;
      end else if (spur_req != spur_ack) begin
        spur_ack++;
        bus.muldiv_done = 1'b1;
        bus.muldiv_done_hart_id = HW'($urandom);
        bus.muldiv_done_rd = RW'($urandom);
        bus.muldiv_result = $urandom;
        err_exp_u++;
      end else begin
        if (bus.muldiv_start) begin
          armed = !u_nodone; k = 0; lat = u_lat; bad = (u_lat >= 2) ? u_bad : 0;
          r_op = bus.muldiv_op; r_a = bus.muldiv_a; r_b = bus.muldiv_b;
          r_hart = bus.muldiv_hart_id; r_rd = bus.muldiv_rd;
        end else if (armed) begin
          k++;
        end
        if (armed && k == lat) begin
          bus.muldiv_done = 1'b1;
          bus.muldiv_done_hart_id = r_hart;
          bus.muldiv_done_rd = r_rd;
          bus.muldiv_result = ref_result(r_op, r_a, r_b);
          armed = 1'b0;
        end else if (armed && k == 1 && bad != 0) begin
          bus.muldiv_done = 1'b1;
          bus.muldiv_done_hart_id = (bad == 2) ? r_hart ^ HW'(1) : r_hart;
          bus.muldiv_done_rd = (bad == 1) ? r_rd ^ RW'(3) : r_rd;
          bus.muldiv_result = $urandom;
          err_exp_u++;
        end
      end
    end
  end

  // Regfile write port: grants after a configurable stall.
  initial begin : wb_sink
    int stall_left = -1;
    wb_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (wb_valid) begin
        if (stall_left < 0) stall_left = wb_stall_cfg;
        if (stall_left > 0) begin
          wb_ready = 1'b0;
          stall_left--;
        end else begin
          wb_ready = 1'b1;
          stall_left = -1;
        end
      end else begin
        wb_ready = 1'b0;
        stall_left = -1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        issued = 1'b0;
      end else begin
        chk("hart_blocked", hart_blocked, (q.size() != 0) ? (NH'(1) << q[0].hart) : '0);
        if (muldiv_err) err_seen++;
        if (bus.muldiv_start) begin
          chk("start_allowed", (q.size() != 0) && !issued, 1);
          if (q.size() != 0 && !issued) begin
            chk("start_op", bus.muldiv_op, q[0].op);
            chk("start_a", bus.muldiv_a, q[0].a);
            chk("start_b", bus.muldiv_b, q[0].b);
            chk("start_hart", bus.muldiv_hart_id, q[0].hart);
            chk("start_rd", bus.muldiv_rd, q[0].rd);
            issued = 1'b1;
          end
        end
        if (wb_valid) begin
          chk("wb_pending", q.size() != 0, 1);
          if (q.size() != 0) begin
            chk("wb_hart", wb_hart_id, q[0].hart);
            chk("wb_rd", wb_rd, q[0].rd);
            chk("wb_data", wb_data, q[0].res);
            if (wb_ready) begin
              chk("wb_after_start", issued, 1);
              void'(q.pop_front());
              issued = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic issue_op(input logic [2:0] op, input logic [31:0] a, b, input logic [HW-1:0] hart,
                          input logic [RW-1:0] rd, input int lat, input int bad, input bit nodone,
                          input int busy_cyc, input int stall);
    exp_t e;
    int   bl = busy_cyc;
    u_lat = lat; u_bad = bad; u_nodone = nodone; wb_stall_cfg = stall;
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_op = op; ex_a = a; ex_b = b; ex_hart = hart; ex_rd = rd;
    bus.muldiv_busy = (bl > 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("ex_ready", ex_ready, bl == 0);
      @(posedge clk); #1;
      if (bl == 0) break;
      bl--;
      if (bl == 0) bus.muldiv_busy = 1'b0;
    end
    ex_valid = 1'b0;
    if (rd != 0) begin
      e.hart = hart; e.rd = rd; e.op = op; e.a = a; e.b = b;
      e.res = nodone ? '1 : ref_result(op, a, b);
      q.push_back(e);
    end
  endtask

  task automatic drain_and_check();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      finish_sim();
    end
    repeat (3) @(posedge clk);
    #1;
    chk("err_count", err_seen, err_exp_u + err_exp_s);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin : stimulus
    bus.muldiv_busy = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {ex_ready, bus.muldiv_start, hart_blocked, wb_valid, muldiv_err}, '0);
    chk("rst_fields", {bus.muldiv_op, bus.muldiv_a, bus.muldiv_b, bus.muldiv_hart_id, bus.muldiv_rd}, '0);
    chk("rst_wb", {wb_hart_id, wb_rd, wb_data}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // basic MUL, busy backpressure, x0, writeback stall, bad done
    issue_op(OP_MUL, 32'd7, 32'd6, 2'd2, 5'd5, 3, 0, 1'b0, 0, 0);
    drain_and_check();
    issue_op(OP_DIVU, 32'd100, 32'd7, 2'd1, 5'd9, 2, 0, 1'b0, 4, 0);
    drain_and_check();
    issue_op(OP_MUL, 32'd3, 32'd3, 2'd0, 5'd0, 1, 0, 1'b0, 0, 0);
    drain_and_check();
    issue_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 2'd3, 5'd12, 1, 0, 1'b0, 0, 5);
    drain_and_check();
    issue_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 5'd5, 4, 1, 1'b0, 0, 0);
    drain_and_check();
    @(posedge clk); #1;
    spur_req++;
    drain_and_check();

    // reset while waiting on the unit
    issue_op(OP_DIV, 32'd50, 32'd5, 2'd1, 5'd7, 0, 0, 1'b1, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    chk("midrst_outputs", {ex_ready, bus.muldiv_start, hart_blocked, wb_valid, muldiv_err}, '0);
    chk("midrst_fields", {bus.muldiv_op, bus.muldiv_a, bus.muldiv_b, bus.muldiv_hart_id, bus.muldiv_rd}, '0);
    chk("midrst_wb", {wb_hart_id, wb_rd, wb_data}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2'd3, 5'd31, 1, 0, 1'b0, 0, 1);
    drain_and_check();

`ifdef MULDIV_ISSUE_TIMEOUT_EN
    issue_op(OP_MUL, 32'd9, 32'd9, 2'd0, 5'd4, 0, 0, 1'b1, 0, 2);
    err_exp_s++;
    drain_and_check();
`endif

    for (int n = 0; n < 40; n++) begin
      issue_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), HW'($urandom),
               ($urandom_range(0, 5) == 0) ? RW'(0) : RW'($urandom_range(1, 31)),
               $urandom_range(0, 4), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0,
               1'b0, $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) begin
        drain_and_check();
        @(posedge clk); #1;
        spur_req++;
      end
      drain_and_check();
    end
    finish_sim();
  end

  initial begin : global_guard
    #400000;
    miscompares++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- Initiator end of the MULDIV request/response interface, between the EX stage of the multi-hart pipeline and the multi-cycle MUL/DIV unit.
- Accepts one M-extension op from EX, issues it to the unit, blocks the issuing hart, and writes the result back to the regfile through an arbitrated write port.
- Holds a single operation in flight.

Parameters:
- XLEN, 32, datapath width
- N_HARTS, 4, number of hardware threads
- HART_ID_W, 2, hart id width (clog2 N_HARTS)
- REG_ADDR_W, 5, register address width
- TIMEOUT_CYCLES, 64, watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- ex_valid  in  1  EX presents an M-ext op
- ex_op  in  3  funct3 (MUL..REMU)
- ex_a, ex_b  in  XLEN  operands rs1, rs2
- ex_hart_id  in  HART_ID_W  issuing hart
- ex_rd  in  REG_ADDR_W  destination register
- ex_ready  out  1  op accepted this cycle
- MULDIV request group, direction output (muldiv_start, muldiv_op, muldiv_a, muldiv_b, muldiv_hart_id, muldiv_rd); same port set as the unit's request input
- MULDIV response group, direction input (muldiv_busy, muldiv_done, muldiv_result, muldiv_done_hart_id, muldiv_done_rd)
- hart_blocked  out  N_HARTS  per-hart pending mask, used by the fetch scheduler
- wb_valid  out  1  writeback request
- wb_hart_id  out  HART_ID_W  writeback hart
- wb_rd  out  REG_ADDR_W  writeback register
- wb_data  out  XLEN  writeback value
- wb_ready  in  1  regfile port granted
- muldiv_err  out  1  one-cycle error pulse

Behaviour:
- Reset: state IDLE. All outputs 0, including every muldiv_* request output, hart_blocked, wb_* and muldiv_err. Reset mid-operation discards the in-flight op with no writeback.
- States:
  - IDLE: ex_ready = ex_valid && !muldiv_busy (combinational).
    - On accept with ex_rd != 0: register op, a, b, hart_id and rd; set hart_blocked[hart]; go to ISSUE.
    - On accept with ex_rd == 0: no issue, no block, stay IDLE.
  - ISSUE: muldiv_start = 1 for exactly this one cycle, with the registered fields on muldiv_op/a/b/hart_id/rd; go to WAIT. muldiv_start is 0 in every other state.
  - WAIT: hold the request fields stable.
    - muldiv_done with done_hart_id and done_rd matching the registered values: capture muldiv_result into the wb buffer; go to WB.
    - muldiv_done with a mismatch: pulse muldiv_err; keep waiting.
  - WB: wb_valid = 1, with wb_hart_id, wb_rd and wb_data stable until wb_ready.
    - On wb_valid && wb_ready, in the same cycle: clear hart_blocked[hart]; go to IDLE.
    - ex_ready is 0 in this state.
- muldiv_done is sampled in ISSUE and WAIT only. muldiv_done in IDLE or WB pulses muldiv_err and is otherwise ignored.
- ex_ready is 0 in ISSUE, WAIT and WB.
- Minimum latency: accept at cycle N, start at N+1, done at N+1+L, wb_valid at N+2+L.
- The next accept is possible in the cycle after the wb handshake.
- hart_blocked has at most one bit set at any time.

Optional Feature:
- Macro: MULDIV_ISSUE_TIMEOUT_EN.
- Defined:
  - Cycle counter, cleared in ISSUE, increments in WAIT.
  - On reaching TIMEOUT_CYCLES with no matching done: pulse muldiv_err, load wb_data = all ones, go to WB. The hart is released after writeback.
  - A done arriving later is treated as a done in IDLE/WB (err pulse, ignored).
- Undefined: no counter; WAIT waits indefinitely.

Decomposition:
- Shared package/defines: XLEN, HART_ID_W, REG_ADDR_W, MULDIV op encodings (funct3 constants), state encoding localparams, and the MULDIV port-list macros from the interface header.
- No sub-module required.
- The watchdog counter may be a small muldiv_watchdog sub-module, instantiated only under the macro.

Test Plan:
- Basic MUL: hart 2, rd=5, a=7, b=6, fake unit answers with done 3 cycles after start, result 42.
  -> start pulses for exactly 1 cycle with a=7 b=6; hart_blocked=4'b0100 until the wb handshake; wb_rd=5, wb_data=42.
- Busy backpressure: muldiv_busy=1 while ex_valid=1 for 4 cycles.
  -> ex_ready=0 and no start during those cycles; accept in the cycle busy drops.
- rd=x0: ex_rd=0, ex_valid=1.
  -> ex_ready=1, no muldiv_start, hart_blocked stays 0, no wb.
- Writeback stall: wb_ready held 0 for 5 cycles after the result.
  -> wb_valid and wb_data held stable for those cycles; ex_ready=0; hart bit is cleared only on the wb_ready cycle.
- Mismatched and spurious done: done with done_rd=6 while expecting 5, then a correct done; also a done pulse in IDLE.
  -> muldiv_err pulses once per bad done; the correct result is written back.
- Reset mid-WAIT, plus timeout when the macro is defined:
  - Assert rst_n low during WAIT -> all outputs 0, next op accepted normally.
  - With MULDIV_ISSUE_TIMEOUT_EN and no done for 64 cycles -> err pulse, wb_data=32'hFFFF_FFFF.
